// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming KxK (K=2/3) max/average pooling over a raster-ordered
// multi-lane feature map, with ready/valid handshakes on input and output.
module pool2d_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int MAX_WIDTH  = 64,
  parameter int DIM_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIM_W-1:0]               cfg_width,
  input  logic [DIM_W-1:0]               cfg_height,
  input  logic [1:0]                     cfg_kernel,
  input  logic                           cfg_mode,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int ACC_W = DATA_WIDTH + 4;
  localparam int MUL_W = ACC_W + 16;
  localparam int BUF_N = MAX_WIDTH / 2;
  localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [DIM_W-1:0]        MAX_W_L  = DIM_W'(MAX_WIDTH);
  localparam logic signed [ACC_W-1:0] RND2     = 2;
  localparam logic signed [MUL_W-1:0] AVG3_MUL = 7282;
  localparam logic signed [MUL_W-1:0] AVG3_RND = 32768;

  // Max or sum, depending on mode.
  function automatic logic signed [ACC_W-1:0] combine(
    input logic                    avg,
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  // Window result to output element: pass-through for max, rounded divide for average.
  function automatic logic [DATA_WIDTH-1:0] finalize(
    input logic                    avg,
    input logic                    k3,
    input logic signed [ACC_W-1:0] v
  );
    logic signed [MUL_W-1:0] ext;
    logic signed [MUL_W-1:0] prod;
    logic signed [ACC_W-1:0] r2;
    ext  = {{(MUL_W-ACC_W){v[ACC_W-1]}}, v};
    prod = ext * AVG3_MUL + AVG3_RND;
    r2   = v + RND2;
    if (!avg) return DATA_WIDTH'(v);
    if (k3)   return DATA_WIDTH'(prod >>> 16);
    return DATA_WIDTH'(r2 >>> 2);
  endfunction

  logic [1:0]                     state_q, state_d;
  logic [DIM_W-1:0]               width_q, width_d, height_q, height_d;
  logic                           k3_q, k3_d, mode_q, mode_d;
  logic [DIM_W-1:0]               col_q, col_d, row_q, row_d;
  logic [1:0]                     kcol_q, kcol_d, krow_q, krow_d;
  logic [IDX_W-1:0]               ocol_q, ocol_d;
  logic                           out_valid_q, out_valid_d;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                           done_q, done_d, cfg_err_q, cfg_err_d;

  logic signed [ACC_W-1:0] run_q [CHANNELS];
  logic signed [ACC_W-1:0] run_d [CHANNELS];
  logic signed [ACC_W-1:0] pbuf_q [BUF_N][CHANNELS];
  logic signed [ACC_W-1:0] pbuf_d [CHANNELS];
  logic signed [ACC_W-1:0] x_ext [CHANNELS];
  logic signed [ACC_W-1:0] hcur [CHANNELS];
  logic signed [ACC_W-1:0] vcomb [CHANNELS];
  logic                    pbuf_we;

  logic       accept, cfg_ok, col_last, row_last, grp_end;
  logic [1:0] kmax;

  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign kmax     = k3_q ? 2'd2 : 2'd1;
  assign col_last = (col_q == width_q - DIM_W'(1));
  assign row_last = (row_q == height_q - DIM_W'(1));
  assign grp_end  = (kcol_q == kmax);
  assign cfg_ok   = ((cfg_kernel == 2'd2) || (cfg_kernel == 2'd3)) &&
                    (cfg_width != '0) && (cfg_width <= MAX_W_L) && (cfg_height != '0);

  // FSM, configuration capture and raster/group counters.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    k3_d      = k3_q;
    mode_d    = mode_q;
    col_d     = col_q;
    row_d     = row_q;
    kcol_d    = kcol_q;
    krow_d    = krow_q;
    ocol_d    = ocol_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d  = S_RUN;
            width_d  = cfg_width;
            height_d = cfg_height;
            k3_d     = (cfg_kernel == 2'd3);
            mode_d   = cfg_mode;
            col_d    = '0;
            row_d    = '0;
            kcol_d   = '0;
            krow_d   = '0;
            ocol_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (col_last) begin
            // Trailing columns never reach grp_end, so they are simply discarded here.
            col_d  = '0;
            kcol_d = '0;
            ocol_d = '0;
            row_d  = row_q + DIM_W'(1);
            krow_d = (krow_q == kmax) ? 2'd0 : krow_q + 2'd1;
            if (row_last) state_d = S_DRAIN;
          end else begin
            col_d  = col_q + DIM_W'(1);
            kcol_d = grp_end ? 2'd0 : kcol_q + 2'd1;
            if (grp_end) ocol_d = ocol_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane horizontal/vertical combine, partial-buffer update and output register load.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pbuf_we     = accept && grp_end && (krow_q != kmax);
    if (out_ready) out_valid_d = 1'b0;
    if (accept && grp_end && (krow_q == kmax)) out_valid_d = 1'b1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      x_ext[c]  = {{4{in_data[c*DATA_WIDTH + DATA_WIDTH - 1]}}, in_data[c*DATA_WIDTH +: DATA_WIDTH]};
      hcur[c]   = (kcol_q == 2'd0) ? x_ext[c] : combine(mode_q, run_q[c], x_ext[c]);
      vcomb[c]  = combine(mode_q, pbuf_q[ocol_q][c], hcur[c]);
      run_d[c]  = accept ? hcur[c] : run_q[c];
      pbuf_d[c] = (krow_q == 2'd0) ? hcur[c] : vcomb[c];
      if (accept && grp_end && (krow_q == kmax))
        out_data_d[c*DATA_WIDTH +: DATA_WIDTH] = finalize(mode_q, k3_q, vcomb[c]);
    end
  end

  // Control, counter, running-value and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      k3_q        <= 1'b0;
      mode_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      kcol_q      <= '0;
      krow_q      <= '0;
      ocol_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) run_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      k3_q        <= k3_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      kcol_q      <= kcol_d;
      krow_q      <= krow_d;
      ocol_q      <= ocol_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      for (int unsigned c = 0; c < CHANNELS; c++) run_q[c] <= run_d[c];
    end
  end

  // Partial row-group buffer; every entry is rewritten on a group's first row before being read.
  always_ff @(posedge clk) begin
    if (pbuf_we) begin
      for (int unsigned c = 0; c < CHANNELS; c++) pbuf_q[ocol_q][c] <= pbuf_d[c];
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench for pool2d_stream: a window-level reference model fills an
// expectation queue per frame; an independent monitor checks every output beat.
module tb_pool2d_stream;
  localparam int DW   = 8;
  localparam int CH   = 4;
  localparam int MAXW = 64;
  localparam int DIMW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIMW-1:0]   cfg_width, cfg_height;
  logic [1:0]        cfg_kernel;
  logic              cfg_mode, start;
  logic              busy, done, cfg_err;
  logic [CH*DW-1:0]  in_data;
  logic              in_valid, in_ready;
  logic [CH*DW-1:0]  out_data;
  logic              out_valid, out_ready;

  always #5 clk = ~clk;

  pool2d_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_WIDTH(MAXW), .DIM_W(DIMW)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_kernel(cfg_kernel), .cfg_mode(cfg_mode), .start(start), .busy(busy),
    .done(done), .cfg_err(cfg_err), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [CH*DW-1:0] exp_q[$];
  int pix [16][64][CH];
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 held low

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Reference model: evaluate each complete KxK window directly.
  task automatic build_expected(input int w, input int h, input int k, input int mode);
    logic [CH*DW-1:0] v;
    longint acc;
    for (int oy = 0; oy < h / k; oy++) begin
      for (int ox = 0; ox < w / k; ox++) begin
        v = '0;
        for (int c = 0; c < CH; c++) begin
          acc = (mode != 0) ? 0 : -100000;
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              if (mode != 0) acc += pix[oy*k+dy][ox*k+dx][c];
              else if (pix[oy*k+dy][ox*k+dx][c] > acc) acc = pix[oy*k+dy][ox*k+dx][c];
            end
          if (mode != 0) acc = (k == 2) ? floordiv(acc + 2, 4) : floordiv(acc * 7282 + 32768, 65536);
          v[c*DW +: DW] = acc[DW-1:0];
        end
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic fill_random(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int col = 0; col < w; col++)
        for (int c = 0; c < CH; c++) pix[r][col][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic start_frame(input int w, input int h, input int k, input int mode);
    @(posedge clk); #1;
    cfg_width  = w[DIMW-1:0];
    cfg_height = h[DIMW-1:0];
    cfg_kernel = k[1:0];
    cfg_mode   = mode[0];
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("no_cfg_err_legal", cfg_err, 0);
  endtask

  task automatic send_pixels(input int w, input int n, input bit gaps);
    int waited;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = pix[i / w][i % w][c][DW-1:0];
      in_valid = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        waited++;
        if (waited > 300) begin
          fail_now("in_ready_wait");
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 500) begin
        fail_now("done_wait");
        return;
      end
    end
    chk("busy_low_at_done", busy, 0);
    chk("all_outputs_seen", exp_q.size(), 0);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int k, input int mode, input bit gaps);
    build_expected(w, h, k, mode);
    start_frame(w, h, k, mode);
    send_pixels(w, w * h, gaps);
    wait_done();
  endtask

  // Output-ready pattern generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on each accepted beat, plus hold-stability and backpressure checks.
  initial begin : monitor
    logic             hold;
    logic [CH*DW-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      if (out_valid && !out_ready) chk("bp_in_ready_low", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      hold = out_valid && !out_ready;
      held = out_data;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL global_timeout: got hang expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int bad [3][3];
    int t;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_width = '0; cfg_height = '0; cfg_kernel = '0; cfg_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Max K=2 W=4 H=2, lane 0 directed.
    rdy_mode = 1;
    fill_random(4, 2);
    pix[0][0][0] = 1; pix[0][1][0] = -5; pix[0][2][0] = 3; pix[0][3][0] = 7;
    pix[1][0][0] = 2; pix[1][1][0] = 0;  pix[1][2][0] = -8; pix[1][3][0] = 4;
    run_frame(4, 2, 2, 0, 0);

    // Average K=2 W=2 H=2 with signed rounding.
    fill_random(2, 2);
    pix[0][0][0] = 1;  pix[0][1][0] = 2;  pix[1][0][0] = 3;  pix[1][1][0] = 5;
    pix[0][0][1] = -1; pix[0][1][1] = -2; pix[1][0][1] = -3; pix[1][1][1] = -5;
    run_frame(2, 2, 2, 1, 0);

    // K=3 constant frames.
    for (int r = 0; r < 3; r++) for (int col = 0; col < 3; col++) for (int c = 0; c < CH; c++) pix[r][col][c] = 100;
    run_frame(3, 3, 3, 1, 0);
    for (int r = 0; r < 3; r++) for (int col = 0; col < 3; col++) for (int c = 0; c < CH; c++) pix[r][col][c] = -128;
    run_frame(3, 3, 3, 0, 0);

    // W=5 H=5 trailing row/column discard, then the same frame under backpressure.
    for (int r = 0; r < 5; r++) for (int col = 0; col < 5; col++) for (int c = 0; c < CH; c++) pix[r][col][c] = 5 * r + col;
    run_frame(5, 5, 2, 0, 0);
    rdy_mode = 2;
    fork
      run_frame(5, 5, 2, 0, 0);
      begin
        t = 0;
        while (!out_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        repeat (15) @(negedge clk);
        rdy_mode = 1;
      end
    join

    // Illegal configurations.
    bad[0] = '{4, 4, 1};
    bad[1] = '{0, 4, 2};
    bad[2] = '{65, 4, 3};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cfg_width = bad[i][0][DIMW-1:0]; cfg_height = bad[i][1][DIMW-1:0]; cfg_kernel = bad[i][2][1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", cfg_err, 1);
      chk("busy_stays_low", busy, 0);
      @(negedge clk);
      chk("cfg_err_single", cfg_err, 0);
      chk("busy_still_low", busy, 0);
    end

    // Degenerate frame: no outputs, done still fires.
    fill_random(1, 1);
    run_frame(1, 1, 2, 0, 0);

    // Mid-frame reset with an output pending.
    rdy_mode = 2;
    fill_random(4, 4);
    build_expected(4, 4, 2, 0);
    start_frame(4, 4, 2, 0);
    send_pixels(4, 6, 0);
    @(negedge clk);
    chk("pre_reset_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    fill_random(6, 4);
    run_frame(6, 4, 2, 1, 1);

    // Randomised frames, including full-width rows.
    fill_random(64, 4);
    run_frame(64, 4, 2, 1, 1);
    fill_random(64, 3);
    run_frame(64, 3, 3, 0, 1);
    for (int f = 0; f < 8; f++) begin
      int w, h, k, m;
      w = int'($urandom_range(1, 64));
      h = int'($urandom_range(1, 12));
      k = int'($urandom_range(2, 3));
      m = int'($urandom_range(0, 1));
      fill_random(w, h);
      run_frame(w, h, k, m, 1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming 2D pooling engine for the NPU post-processing path. It consumes a raster-ordered feature map of CHANNELS parallel signed lanes and emits one pooled word per non-overlapping KxK window. It supports max and average modes, K = 2 or 3, and a runtime frame width and height. Ready/valid handshakes on both sides let it sit between the activation unit and the output writeback buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, signed element width per lane
- CHANNELS, 4, parallel independent lanes; lane c is bits [c*DATA_WIDTH +: DATA_WIDTH]
- MAX_WIDTH, 64, largest supported cfg_width (even, ≥ 2)
- DIM_W, 8, width of the cfg_width and cfg_height fields

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_width  in  DIM_W  input columns W; legal range 1..MAX_WIDTH
- cfg_height  in  DIM_W  input rows H; legal range ≥ 1
- cfg_kernel  in  2  K; legal values 2 or 3
- cfg_mode  in  1  0 = max, 1 = average
- start  in  1  single-cycle pulse; samples cfg_* into internal registers
- busy  out  1  high from an accepted start until done
- done  out  1  single-cycle pulse at frame completion
- cfg_err  out  1  single-cycle pulse when start is rejected
- in_data  in  CHANNELS*DATA_WIDTH  input pixel vector
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_data  out  CHANNELS*DATA_WIDTH  pooled vector
- out_valid  out  1  output valid
- out_ready  in  1  output ready

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on start when the configuration is legal: K ∈ {2,3}, 1 ≤ W ≤ MAX_WIDTH, H ≥ 1. This clears all counters.
- An illegal configuration at start raises cfg_err the next cycle, and the block stays in IDLE.
- start is ignored outside IDLE.
- RUN: each accepted pixel (in_valid && in_ready) advances the column counter (0..W-1). When the column counter wraps, the row counter advances.
- RUN → DRAIN after accepting the pixel at row H-1, column W-1.
- DRAIN → IDLE once out_valid is low or is being accepted that cycle. done pulses on that transition.
- Output geometry is floor(W/K) x floor(H/K).
  - The trailing W mod K columns and H mod K rows are still accepted but do not affect any output.
  - If W < K or H < K, there are no outputs; done still fires after all W*H pixels are accepted.
- Horizontal combine: a running register per lane holds the max or sum of the current group's pixels within the row.
- Vertical combine: a partial buffer holds MAX_WIDTH/2 entries per lane, indexed by output column. It is a register array with combinational read and same-cycle write.
- On the last pixel of a column group in the first row of a row group, the running value is written to the buffer.
- In middle rows, the running value is combined with the buffer entry and written back.
- In the last row, the combined result goes to the output register; no buffer write occurs.
- Accumulator width per lane is DATA_WIDTH+4, signed.
- Max mode: signed compare; on ties either value may be kept (the result is identical).
- Average, K=2: out = (sum + 2) >>> 2.
- Average, K=3: out = (sum*7282 + 32768) >>> 16, signed, with an intermediate width of at least DATA_WIDTH+4+14.
- Results always fit in DATA_WIDTH; no saturation is required.
- Lanes are fully independent and share the counters and the FSM.

## Timing
- Reset values: busy=0, done=0, cfg_err=0, in_ready=0, out_valid=0, out_data=0, FSM=IDLE.
- Reset mid-frame discards all state immediately. No done is produced.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is combinational from out_ready.
- Latency: out_valid rises in the cycle after the window's final pixel is accepted. Throughput is 1 pixel/cycle with no stalls.
- out_data and out_valid are held stable while out_valid && !out_ready.
- An output being accepted in the same cycle as a new window completion is legal. The output register reloads and out_valid stays high.
- busy rises the cycle after an accepted start. busy falls in the same cycle that done is high.
- The buffer index wraps per row. No state carries across frames.

## Test plan
- Max mode, K=2, W=4, H=2, CHANNELS lane 0: row0 = 1, -5, 3, 7 and row1 = 2, 0, -8, 4. Required outputs: 2 then 7, followed by a done pulse.
- Average mode, K=2, W=2, H=2: lane 0 = 1, 2, 3, 5 produces 3; lane 1 = -1, -2, -3, -5 produces -3. Both come out in a single output beat.
- Average mode, K=3, W=3, H=3, all pixels 100: output 100. With all pixels -128 in max mode: output -128.
- K=2, W=5, H=5, pixel value = 5*row + col: 25 pixels are accepted and exactly 4 outputs are produced (6, 8, 16, 18), then done.
- Backpressure: using the case above with out_ready held low after the first output. Required: in_ready drops, out_data stays at 6 until out_ready rises, and no pixel or output is lost.
- Control edges:
  - start with cfg_kernel=1 gives a cfg_err pulse and busy stays 0.
  - W=1, H=1, K=2 accepts 1 pixel, produces no output, and pulses done.
  - rst asserted mid-frame clears out_valid and in_ready; a following legal frame produces correct results.
